// File: rtl/icache_refill_ctrl_pkg.sv
// Shared geometry, derived widths and state encoding for the icache line-refill sequencer.
package icache_refill_ctrl_pkg;

    localparam int SETS       = 32;
    localparam int WAYS       = 4;
    localparam int LINE_BYTES = 64;
    localparam int BUS_BYTES  = 8;
    localparam int BLK_W      = 32;

    localparam int BEATS  = LINE_BYTES / BUS_BYTES;
    localparam int SET_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int TAG_W  = BLK_W - SET_W;
    localparam int DATA_W = BUS_BYTES * 8;

    typedef logic [BLK_W-1:0] blk_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RECV  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_t;

    function automatic logic [SET_W-1:0] set_of(input blk_t blk);
        return blk[SET_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input blk_t blk);
        return blk[BLK_W-1:SET_W];
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Miss, next-level memory and array-write signals of the refill sequencer.
interface icache_refill_ctrl_if;
    import icache_refill_ctrl_pkg::*;

    logic               flush;
    logic               miss_valid;
    logic               miss_ready;
    blk_t               miss_blk;
    logic [WAY_W-1:0]   miss_way;
    logic               mem_req_valid;
    logic               mem_req_ready;
    blk_t               mem_req_blk;
    logic               mem_rsp_valid;
    logic [DATA_W-1:0]  mem_rsp_data;
    logic               mem_rsp_last;
    logic               data_we;
    logic [SET_W-1:0]   data_set;
    logic [WAY_W-1:0]   data_way;
    logic [BEAT_W-1:0]  data_beat;
    logic [DATA_W-1:0]  data_wdata;
    logic               tag_we;
    logic [SET_W-1:0]   tag_set;
    logic [WAY_W-1:0]   tag_way;
    logic [TAG_W-1:0]   tag_wdata;
    logic               refill_done;
    blk_t               refill_blk;
    logic               err;

    modport master (
        input  flush, miss_valid, miss_blk, miss_way, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, mem_rsp_last,
        output miss_ready, mem_req_valid, mem_req_blk, data_we, data_set, data_way,
               data_beat, data_wdata, tag_we, tag_set, tag_way, tag_wdata,
               refill_done, refill_blk, err
    );

    modport slave (
        output flush, miss_valid, miss_blk, miss_way, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, mem_rsp_last,
        input  miss_ready, mem_req_valid, mem_req_blk, data_we, data_set, data_way,
               data_beat, data_wdata, tag_we, tag_set, tag_way, tag_wdata,
               refill_done, refill_blk, err
    );

endinterface

// File: rtl/icache_refill_ctrl.sv
// Single-outstanding icache line refill: request, beat-by-beat data write, then tag install.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    icache_refill_ctrl_if.master  bus
);

    refill_state_t      r_state;
    blk_t               r_blk;
    logic [WAY_W-1:0]   r_way;
    logic [BEAT_W-1:0]  r_cnt;
    logic               r_miss_ready;
    logic               r_mem_req_valid;
    logic               r_tag_we;
    logic               r_refill_done;
    logic               r_err;

    logic               w_beat_last;
    logic               w_last_bad;
    logic               w_data_we;

    // Beat classification and the same-cycle data write strobe
    always_comb begin
        w_beat_last = (r_cnt == BEAT_W'(BEATS - 1));
        w_last_bad  = (bus.mem_rsp_last != w_beat_last);
        if ((r_state == ST_RECV) && bus.mem_rsp_valid && !bus.flush) begin
            w_data_we = 1'b1;
        end else begin
            w_data_we = 1'b0;
        end
    end

    // Refill sequencer with registered handshake, tag and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_blk           <= {BLK_W{1'b0}};
            r_way           <= {WAY_W{1'b0}};
            r_cnt           <= {BEAT_W{1'b0}};
            r_miss_ready    <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_tag_we        <= 1'b0;
            r_refill_done   <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_tag_we      <= 1'b0;
            r_refill_done <= 1'b0;

            // Beats only belong in RECV/DRAIN; anywhere else they are a protocol error
            if (bus.mem_rsp_valid) begin
                case (r_state)
                    ST_RECV, ST_DRAIN: begin
                        if (w_last_bad) begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_err <= 1'b1;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.miss_valid && r_miss_ready && !bus.flush) begin
                        r_blk           <= bus.miss_blk;
                        r_way           <= bus.miss_way;
                        r_cnt           <= {BEAT_W{1'b0}};
                        r_miss_ready    <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= {BEAT_W{1'b0}};
                        r_state         <= bus.flush ? ST_DRAIN : ST_RECV;
                    end else if (bus.flush) begin
                        r_mem_req_valid <= 1'b0;
                        r_miss_ready    <= 1'b1;
                        r_state         <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (bus.mem_rsp_valid) begin
                        r_cnt <= r_cnt + BEAT_W'(1);
                        if (w_beat_last && bus.flush) begin
                            r_miss_ready <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else if (w_beat_last) begin
                            r_tag_we      <= 1'b1;
                            r_refill_done <= 1'b1;
                            r_state       <= ST_DONE;
                        end else if (bus.flush) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (bus.flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.mem_rsp_valid) begin
                        r_cnt <= r_cnt + BEAT_W'(1);
                        if (w_beat_last) begin
                            r_miss_ready <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    r_miss_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_mem_req_valid <= 1'b0;
                    r_miss_ready    <= 1'b1;
                    r_state         <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.miss_ready    = r_miss_ready;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_req_blk   = r_blk;
    assign bus.data_we       = w_data_we;
    assign bus.data_set      = set_of(r_blk);
    assign bus.data_way      = r_way;
    assign bus.data_beat     = r_cnt;
    assign bus.data_wdata    = w_data_we ? bus.mem_rsp_data : {DATA_W{1'b0}};
    assign bus.tag_we        = r_tag_we;
    assign bus.tag_set       = set_of(r_blk);
    assign bus.tag_way       = r_way;
    assign bus.tag_wdata     = tag_of(r_blk);
    assign bus.refill_done   = r_refill_done;
    assign bus.refill_blk    = r_blk;
    assign bus.err           = r_err;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized scenario bench for icache_refill_ctrl against a transaction-level refill model.
module tb_icache_refill_ctrl;
    import icache_refill_ctrl_pkg::*;

    typedef struct packed {
        logic [SET_W-1:0]  set;
        logic [WAY_W-1:0]  way;
        logic [BEAT_W-1:0] beat;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    wr_t  got_wr[$];
    wr_t  exp_wr[$];
    int   tag_cnt, done_cnt, tag_cyc, done_cyc;
    logic [TAG_W-1:0] got_tag;
    logic [SET_W-1:0] got_tag_set;
    logic [WAY_W-1:0] got_tag_way;
    blk_t got_done_blk;
    int   acc_cyc, last_beat_cyc, exp_done_cyc;
    logic post_ready;

    icache_refill_ctrl_if bus();
    icache_refill_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe array writes and completion pulses mid-cycle
    always @(negedge clk) begin
        if (bus.data_we === 1'b1) begin
            wr_t w;
            w.set = bus.data_set; w.way = bus.data_way; w.beat = bus.data_beat; w.data = bus.data_wdata;
            got_wr.push_back(w);
        end
        if (bus.tag_we === 1'b1) begin
            tag_cnt++; tag_cyc = cyc;
            got_tag = bus.tag_wdata; got_tag_set = bus.tag_set; got_tag_way = bus.tag_way;
        end
        if (bus.refill_done === 1'b1) begin
            done_cnt++; done_cyc = cyc; got_done_blk = bus.refill_blk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.flush = 1'b0; bus.miss_valid = 1'b0; bus.miss_blk = '0; bus.miss_way = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0; bus.mem_rsp_last = 1'b0;
    endtask

    task automatic clear_obs();
        got_wr.delete(); tag_cnt = 0; done_cnt = 0; tag_cyc = -1; done_cyc = -1;
    endtask

    // One complete miss transaction; flush_at/bad_at < 0 disables flush / bad last marker
    task automatic run_refill(input blk_t blk, input logic [WAY_W-1:0] way, input int req_wait,
                              input int gap, input int flush_at, input int bad_at);
        logic [DATA_W-1:0] beat_data [BEATS];
        bit  completes;
        int  n;
        wr_t e;
        completes = (flush_at < 0);
        exp_wr.delete();
        for (int b = 0; b < BEATS; b++) begin
            beat_data[b] = {$urandom, $urandom};
            if (completes || b < flush_at) begin
                e.set = blk[SET_W-1:0]; e.way = way; e.beat = BEAT_W'(b); e.data = beat_data[b];
                exp_wr.push_back(e);
            end
        end
        n = 0;
        while (bus.miss_ready !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (bus.miss_ready !== 1'b1) begin
            failures++; $display("FAIL miss_ready_wait got=%b want=1", bus.miss_ready);
        end
        clear_obs();
        bus.miss_valid = 1'b1; bus.miss_blk = blk; bus.miss_way = way;
        acc_cyc = cyc;
        tick();
        bus.miss_valid = 1'b0;
        for (int i = 0; i <= req_wait; i++) begin
            bus.mem_req_ready = (i == req_wait) ? 1'b1 : 1'b0;
            checks++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_blk !== blk || bus.miss_ready !== 1'b0) begin
                failures++;
                $display("FAIL req_phase wait=%0d got valid=%b blk=%h miss_ready=%b want valid=1 blk=%h miss_ready=0",
                         i, bus.mem_req_valid, bus.mem_req_blk, bus.miss_ready, blk);
            end
            tick();
        end
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (b > 0) repeat (gap) tick();
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = beat_data[b];
            bus.mem_rsp_last  = ((b == BEATS - 1) != (b == bad_at)) ? 1'b1 : 1'b0;
            bus.flush         = (b == flush_at) ? 1'b1 : 1'b0;
            last_beat_cyc = cyc;
            tick();
            bus.mem_rsp_valid = 1'b0; bus.mem_rsp_last = 1'b0; bus.flush = 1'b0; bus.mem_rsp_data = '0;
        end
        post_ready = bus.miss_ready;
        repeat (3) tick();
        exp_done_cyc = acc_cyc + 1 + req_wait + ((BEATS - 1) * (gap + 1) + 1) + 1;

        checks++;
        if (got_wr.size() != exp_wr.size()) begin
            failures++; $display("FAIL wr_count got=%0d want=%0d", got_wr.size(), exp_wr.size());
        end
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
            checks++;
            if (got_wr[i] !== exp_wr[i]) begin
                failures++; $display("FAIL wr_entry idx=%0d got=%h want=%h", i, got_wr[i], exp_wr[i]);
            end
        end
        checks++;
        if (tag_cnt != (completes ? 1 : 0) || done_cnt != (completes ? 1 : 0)) begin
            failures++; $display("FAIL install_count got tag=%0d done=%0d want=%0d", tag_cnt, done_cnt, completes ? 1 : 0);
        end
        if (completes) begin
            checks++;
            if (got_tag !== blk[BLK_W-1:SET_W] || got_tag_set !== blk[SET_W-1:0] || got_tag_way !== way) begin
                failures++; $display("FAIL tag_entry got tag=%h set=%h way=%0d want tag=%h set=%h way=%0d",
                                     got_tag, got_tag_set, got_tag_way, blk[BLK_W-1:SET_W], blk[SET_W-1:0], way);
            end
            checks++;
            if (tag_cyc != last_beat_cyc + 1) begin
                failures++; $display("FAIL tag_after_last got cyc=%0d want=%0d", tag_cyc, last_beat_cyc + 1);
            end
            checks++;
            if (done_cyc != exp_done_cyc || got_done_blk !== blk) begin
                failures++; $display("FAIL done_timing got cyc=%0d blk=%h want cyc=%0d blk=%h",
                                     done_cyc, got_done_blk, exp_done_cyc, blk);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        #12;
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.data_we !== 1'b0 || bus.tag_we !== 1'b0 ||
            bus.refill_done !== 1'b0 || bus.err !== 1'b0 || bus.mem_req_blk !== '0) begin
            failures++; $display("FAIL reset_outputs got req=%b we=%b tag=%b done=%b err=%b blk=%h want all 0",
                                 bus.mem_req_valid, bus.data_we, bus.tag_we, bus.refill_done, bus.err, bus.mem_req_blk);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.miss_ready !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release got miss_ready=%b req=%b want 1/0", bus.miss_ready, bus.mem_req_valid);
        end
    endtask

    task automatic test_basic();
        run_refill(32'h0000_1234, 2'd2, 0, 0, -1, -1);
        checks++;
        if (done_cyc - acc_cyc != 10 || got_tag !== 27'h91 || got_tag_set !== 5'h14 || post_ready !== 1'b0) begin
            failures++; $display("FAIL basic_refill got latency=%0d tag=%h set=%h ready=%b want 10/91/14/0",
                                 done_cyc - acc_cyc, got_tag, got_tag_set, post_ready);
        end
    endtask

    task automatic test_backpressure();
        run_refill($urandom, 2'd1, 5, 0, -1, -1);
        checks++;
        if (done_cyc - acc_cyc != 15) begin
            failures++; $display("FAIL backpressure_latency got=%0d want=15", done_cyc - acc_cyc);
        end
    endtask

    task automatic test_gapped();
        run_refill($urandom, 2'd3, 0, 1, -1, -1);
        checks++;
        if (got_wr.size() != 8 || tag_cnt != 1 || done_cyc - acc_cyc != 17) begin
            failures++; $display("FAIL gapped got writes=%0d tags=%0d latency=%0d want 8/1/17",
                                 got_wr.size(), tag_cnt, done_cyc - acc_cyc);
        end
    endtask

    task automatic test_flush_recv();
        run_refill($urandom, 2'd0, 1, 0, 3, -1);
        checks++;
        if (got_wr.size() != 3 || post_ready !== 1'b1 || done_cnt != 0) begin
            failures++; $display("FAIL flush_recv got writes=%0d ready_after_last=%b done=%0d want 3/1/0",
                                 got_wr.size(), post_ready, done_cnt);
        end
    endtask

    task automatic test_flush_req();
        clear_obs();
        bus.miss_valid = 1'b1; bus.flush = 1'b1; bus.miss_blk = $urandom;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.miss_ready !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL flush_with_miss got miss_ready=%b req=%b want 1/0", bus.miss_ready, bus.mem_req_valid);
        end
        tick();
        bus.miss_valid = 1'b0;
        checks++;
        if (bus.mem_req_valid !== 1'b1) begin
            failures++; $display("FAIL flush_req_setup got req=%b want 1", bus.mem_req_valid);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.mem_req_valid !== 1'b0 || bus.miss_ready !== 1'b1) begin
            failures++; $display("FAIL flush_req got req=%b miss_ready=%b want 0/1", bus.mem_req_valid, bus.miss_ready);
        end
        repeat (4) tick();
        checks++;
        if (got_wr.size() != 0 || tag_cnt != 0 || done_cnt != 0) begin
            failures++; $display("FAIL flush_req_quiet got writes=%0d tags=%0d done=%0d want 0", got_wr.size(), tag_cnt, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            int fl;
            fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
            run_refill($urandom, WAY_W'($urandom_range(0, WAYS - 1)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2)), fl, -1);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            failures++; $display("FAIL err_clean got=%b want=0", bus.err);
        end
    endtask

    task automatic test_last_mismatch();
        run_refill($urandom, 2'd2, 0, 0, -1, 5);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++; $display("FAIL err_set got=%b want=1", bus.err);
        end
        run_refill($urandom, 2'd1, 0, 0, -1, -1);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++; $display("FAIL err_sticky got=%b want=1", bus.err);
        end
    endtask

    task automatic test_async_reset();
        bus.miss_valid = 1'b1; bus.miss_blk = $urandom; bus.miss_way = 2'd3;
        tick();
        bus.miss_valid = 1'b0; bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = {$urandom, $urandom};
            tick();
        end
        #1;
        checks++;
        if (bus.data_we !== 1'b1) begin
            failures++; $display("FAIL pre_reset_write got=%b want=1", bus.data_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.data_we !== 1'b0 || bus.data_wdata !== '0 || bus.mem_req_valid !== 1'b0 || bus.tag_we !== 1'b0 ||
            bus.refill_done !== 1'b0 || bus.err !== 1'b0 || bus.data_beat !== '0) begin
            failures++; $display("FAIL async_reset got we=%b wdata=%h req=%b tag=%b done=%b err=%b beat=%0d want all 0",
                                 bus.data_we, bus.data_wdata, bus.mem_req_valid, bus.tag_we, bus.refill_done,
                                 bus.err, bus.data_beat);
        end
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.miss_ready !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL async_release got miss_ready=%b req=%b want 1/0", bus.miss_ready, bus.mem_req_valid);
        end
        run_refill($urandom, 2'd0, 2, 0, -1, -1);
    endtask

    task automatic test_idle_rsp_err();
        checks++;
        if (bus.err !== 1'b0) begin
            failures++; $display("FAIL idle_err_pre got=%b want=0", bus.err);
        end
        bus.mem_rsp_valid = 1'b1;
        tick();
        bus.mem_rsp_valid = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.data_we !== 1'b0) begin
            failures++; $display("FAIL idle_rsp_err got err=%b we=%b want 1/0", bus.err, bus.data_we);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_flush_recv();
        test_flush_req();
        test_back_to_back();
        test_last_mismatch();
        test_async_reset();
        test_idle_rsp_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-refill sequencer for the physically-tagged, virtually-indexed icache. Accepts one line miss at a time from the fetch-side miss detector and issues a single line request to next-level storage. Collects the response beats and writes each beat into the data SRAM, then writes the tag/valid entry of the chosen way. Sits between the icache arrays and the next-level memory port; one outstanding refill maximum.

Parameters:
SETS, 32, number of sets; index = miss_blk[$clog2(SETS)-1:0]
WAYS, 4, associativity; victim way supplied by requester
LINE_BYTES, 64, cacheline size (matches CACHELINE_SIZE)
BUS_BYTES, 8, next-level data beat width; BEATS = LINE_BYTES/BUS_BYTES (power of two, >=2)
BLK_W, 32, block-address width (byte address >> log2(LINE_BYTES))

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  cancel current refill (fence.i / redirect)
miss_valid  in  1  miss request
miss_ready  out  1  controller can accept miss
miss_blk  in  BLK_W  missing line block address
miss_way  in  log2(WAYS)  victim way
mem_req_valid  out  1  line read request
mem_req_ready  in  1  next level accepts request
mem_req_blk  out  BLK_W  requested block address
mem_rsp_valid  in  1  response beat valid (no backpressure)
mem_rsp_data  in  BUS_BYTES*8  beat data, critical-word order not used (beat 0 first)
mem_rsp_last  in  1  final beat marker
data_we  out  1  data SRAM beat write
data_set  out  log2(SETS)  write set
data_way  out  log2(WAYS)  write way
data_beat  out  log2(BEATS)  beat slot within line
data_wdata  out  BUS_BYTES*8  beat data
tag_we  out  1  tag/valid write
tag_set  out  log2(SETS)  tag set
tag_way  out  log2(WAYS)  tag way
tag_wdata  out  BLK_W-log2(SETS)  tag = miss_blk >> log2(SETS)
refill_done  out  1  one-cycle pulse: line installed
refill_blk  out  BLK_W  block of completed refill
err  out  1  sticky: mem_rsp_last mismatched beat count

Behaviour:
- Reset (rst low, async): state IDLE, beat counter 0, all outputs 0 except miss_ready=1 after reset release; err cleared only by reset.
- States: IDLE, REQ, RECV, DRAIN, DONE.
- IDLE: miss_ready=1. miss_valid&miss_ready&!flush -> latch blk/way, go REQ. Flush in IDLE is a no-op.
- REQ: mem_req_valid=1, mem_req_blk=latched blk; held stable until mem_req_ready. Handshake -> RECV. Flush in REQ before handshake -> IDLE, no request issued. Flush in the handshake cycle -> DRAIN.
- RECV: each mem_rsp_valid -> data_we=1 in the same cycle (combinational from beat) with data_beat=counter, set/way from latch; counter++ (wraps mod BEATS). Beat with counter==BEATS-1 -> DONE. Beats may have gaps.
- DONE (one cycle): tag_we=1, refill_done=1, refill_blk=latched blk -> IDLE. Tag written strictly after final data beat; the next miss is accepted no earlier than the cycle after DONE (latency: miss accept -> refill_done = 1 + req wait + BEATS beats + 1, minimum BEATS+2 cycles).
- Flush in RECV: beats still consumed, data_we suppressed for current and remaining beats, go DRAIN; counter continues.
- DRAIN: consume beats with writes suppressed; after beat BEATS-1 -> IDLE with no tag_we/refill_done. Stale data in the victim way is harmless: its valid is not set by this refill. The tag array owner invalidates it on flush.
- err: set when mem_rsp_last=1 on a beat with counter!=BEATS-1, or =0 on counter==BEATS-1. Sequencing uses the counter only.
- mem_rsp_valid in IDLE/REQ/DONE: ignored, sets err.
- Flush and miss_valid in the same cycle in IDLE: miss not accepted.

Decomposition:
- icache_pkg: SETS/WAYS/LINE_BYTES/BUS_BYTES defaults, derived BEATS and index/tag widths, refill_state_t enum.
- Single module. The beat counter is inline; no sub-module is warranted.

Test Plan:
- Basic refill: miss_blk=0x1234, way=2, mem_req_ready immediate, 8 back-to-back beats -> mem_req_blk=0x1234; data_we on beats 0..7 with set=0x14, way=2; tag_we tag=0x91 one cycle after beat 7; refill_done at cycle 10 after accept.
- Request backpressure: mem_req_ready low 5 cycles -> mem_req_valid/blk stable for 5 cycles; miss_ready=0 throughout; completion delayed by 5.
- Gapped beats: rsp_valid every other cycle -> 8 writes, data_beat 0..7 in order, single tag_we.
- Flush in RECV after beat 3 -> no data_we for beats 3..7; no tag_we or refill_done; miss_ready=1 the cycle after beat 7.
- Flush in REQ before ready -> mem_req_valid drops next cycle; IDLE; no beats expected.
- last mismatch: mem_rsp_last on beat 5 -> err=1 stays set; refill still completes after beat 7. Async reset mid-RECV -> outputs 0 immediately, miss_ready=1 after release.
